// File: rtl/clock_alarm.sv
// rtl/clock_alarm.sv - alarm clock FSM with snooze, ring timeout and set-time validation
module clock_alarm #(
  parameter int P_SEC_BIT    = 6,
  parameter int P_MIN_BIT    = 6,
  parameter int P_HOUR_BIT   = 5,
  parameter int P_RING_SEC   = 60,
  parameter int P_SNOOZE_MIN = 5,
  parameter int P_MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_SEC_BIT-1:0]  sec,
  input  logic [P_MIN_BIT-1:0]  min,
  input  logic [P_HOUR_BIT-1:0] hour,
  input  logic                  i_alarm_en,
  input  logic                  i_set,
  input  logic [P_HOUR_BIT-1:0] i_set_hour,
  input  logic [P_MIN_BIT-1:0]  i_set_min,
  input  logic                  i_snooze,
  input  logic                  i_stop,
  output logic                  o_ring,
  output logic                  o_armed,
  output logic [P_HOUR_BIT-1:0] o_alarm_hour,
  output logic [P_MIN_BIT-1:0]  o_alarm_min,
  output logic                  o_set_err
);

  localparam int RC_W = $clog2(P_RING_SEC + 1);
  localparam int SC_W = $clog2(P_MAX_SNOOZE + 1);

  localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);
  localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
  localparam logic [P_MIN_BIT:0]    MIN_WRAP = (P_MIN_BIT + 1)'(60);
  localparam logic [P_MIN_BIT:0]    SNZ_ADD  = (P_MIN_BIT + 1)'(P_SNOOZE_MIN);
  localparam logic [RC_W-1:0]       RING_END = RC_W'(P_RING_SEC);
  localparam logic [SC_W-1:0]       SNZ_MAX  = SC_W'(P_MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  state_t                  state, state_nxt;
  logic [P_SEC_BIT-1:0]    prev_sec, prev_sec_nxt;
  logic [P_HOUR_BIT-1:0]   tgt_hour, tgt_hour_nxt, alarm_hour_nxt;
  logic [P_MIN_BIT-1:0]    tgt_min, tgt_min_nxt, alarm_min_nxt;
  logic [RC_W-1:0]         ring_cnt, ring_cnt_nxt;
  logic [SC_W-1:0]         snz_cnt, snz_cnt_nxt;
  logic                    set_err_nxt;

  logic                    tick, hit, set_legal;
  logic [P_MIN_BIT:0]      snz_min_sum;
  logic [P_HOUR_BIT-1:0]   snz_hour;
  logic [P_MIN_BIT-1:0]    snz_min;

  assign tick        = (sec != prev_sec);
  assign hit         = tick && (sec == '0) && (hour == tgt_hour) && (min == tgt_min);
  assign set_legal   = (i_set_hour <= HOUR_MAX) && (i_set_min <= MIN_MAX);
  assign snz_min_sum = {1'b0, min} + SNZ_ADD;

  // Snooze target is relative to wall time, wrapping minutes into hours and 23 -> 0
  always_comb begin
    snz_min  = P_MIN_BIT'(snz_min_sum);
    snz_hour = hour;
    if (snz_min_sum >= MIN_WRAP) begin
      snz_min  = P_MIN_BIT'(snz_min_sum - MIN_WRAP);
      snz_hour = (hour >= HOUR_MAX) ? '0 : hour + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_sec_nxt   = sec;
    tgt_hour_nxt   = tgt_hour;
    tgt_min_nxt    = tgt_min;
    alarm_hour_nxt = o_alarm_hour;
    alarm_min_nxt  = o_alarm_min;
    ring_cnt_nxt   = ring_cnt;
    snz_cnt_nxt    = snz_cnt;
    set_err_nxt    = 1'b0;
    if (i_set && !set_legal) begin
      // A rejected set freezes everything, including the tick history
      prev_sec_nxt = prev_sec;
      set_err_nxt  = 1'b1;
    end else if (i_set) begin
      alarm_hour_nxt = i_set_hour;
      alarm_min_nxt  = i_set_min;
      tgt_hour_nxt   = i_set_hour;
      tgt_min_nxt    = i_set_min;
      ring_cnt_nxt   = '0;
      snz_cnt_nxt    = '0;
      state_nxt      = i_alarm_en ? ARMED : IDLE;
    end else if (!i_alarm_en) begin
      state_nxt    = IDLE;
      tgt_hour_nxt = o_alarm_hour;
      tgt_min_nxt  = o_alarm_min;
      ring_cnt_nxt = '0;
      snz_cnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt    = ARMED;
          tgt_hour_nxt = o_alarm_hour;
          tgt_min_nxt  = o_alarm_min;
        end
        ARMED, SNOOZE: begin
          if (hit) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end
        end
        RINGING: begin
          if (i_stop) begin
            state_nxt    = ARMED;
            tgt_hour_nxt = o_alarm_hour;
            tgt_min_nxt  = o_alarm_min;
            snz_cnt_nxt  = '0;
          end else if (i_snooze && (snz_cnt < SNZ_MAX)) begin
            state_nxt    = SNOOZE;
            snz_cnt_nxt  = snz_cnt + 1'b1;
            tgt_hour_nxt = snz_hour;
            tgt_min_nxt  = snz_min;
          end else if (tick) begin
            ring_cnt_nxt = ring_cnt + 1'b1;
            if (ring_cnt_nxt == RING_END) begin
              state_nxt    = ARMED;
              tgt_hour_nxt = o_alarm_hour;
              tgt_min_nxt  = o_alarm_min;
              snz_cnt_nxt  = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      prev_sec     <= '0;
      tgt_hour     <= '0;
      tgt_min      <= '0;
      o_alarm_hour <= '0;
      o_alarm_min  <= '0;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      o_ring       <= 1'b0;
      o_armed      <= 1'b0;
      o_set_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev_sec     <= prev_sec_nxt;
      tgt_hour     <= tgt_hour_nxt;
      tgt_min      <= tgt_min_nxt;
      o_alarm_hour <= alarm_hour_nxt;
      o_alarm_min  <= alarm_min_nxt;
      ring_cnt     <= ring_cnt_nxt;
      snz_cnt      <= snz_cnt_nxt;
      o_ring       <= (state_nxt == RINGING);
      o_armed      <= (state_nxt == ARMED) || (state_nxt == SNOOZE);
      o_set_err    <= set_err_nxt;
    end
  end

endmodule

// File: tb/tb_clock_alarm.sv
// tb/tb_clock_alarm.sv - directed bench for clock_alarm against a minute-of-day model
module tb_clock_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sec, min, i_set_min, o_alarm_min;
  logic [4:0] hour, i_set_hour, o_alarm_hour;
  logic       i_alarm_en, i_set, i_snooze, i_stop;
  logic       o_ring, o_armed, o_set_err;

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  cmp_en   = 1'b0;

  clock_alarm dut (
    .clk(clk), .reset(reset), .sec(sec), .min(min), .hour(hour),
    .i_alarm_en(i_alarm_en), .i_set(i_set), .i_set_hour(i_set_hour), .i_set_min(i_set_min),
    .i_snooze(i_snooze), .i_stop(i_stop), .o_ring(o_ring), .o_armed(o_armed),
    .o_alarm_hour(o_alarm_hour), .o_alarm_min(o_alarm_min), .o_set_err(o_set_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: alarm and target held as minute-of-day, snooze target via modular arithmetic
  bit m_ring, m_armed, m_err;
  int m_alarm, m_tgt, m_snz, m_cnt, m_prev;
  bit m_tick, m_hit;
  int m_now;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ring = 0; m_armed = 0; m_err = 0;
      m_alarm = 0; m_tgt = 0; m_snz = 0; m_cnt = 0; m_prev = 0;
    end else begin
      m_now  = int'(hour) * 60 + int'(min);
      m_tick = int'(sec) != m_prev;
      m_hit  = m_tick && sec == 0 && m_now == m_tgt;
      m_err  = 0;
      if (i_set && (i_set_hour > 23 || i_set_min > 59)) begin
        m_err = 1;
      end else begin
        m_prev = int'(sec);
        if (i_set) begin
          m_alarm = int'(i_set_hour) * 60 + int'(i_set_min);
          m_tgt = m_alarm; m_snz = 0; m_cnt = 0;
          m_ring = 0; m_armed = i_alarm_en;
        end else if (!i_alarm_en) begin
          m_ring = 0; m_armed = 0; m_tgt = m_alarm; m_cnt = 0; m_snz = 0;
        end else if (m_ring) begin
          if (i_stop) begin
            m_ring = 0; m_armed = 1; m_tgt = m_alarm; m_snz = 0;
          end else if (i_snooze && m_snz < 3) begin
            m_ring = 0; m_armed = 1; m_snz++; m_tgt = (m_now + 5) % 1440;
          end else if (m_tick) begin
            m_cnt++;
            if (m_cnt == 60) begin
              m_ring = 0; m_armed = 1; m_tgt = m_alarm; m_snz = 0;
            end
          end
        end else if (!m_armed) begin
          m_armed = 1; m_tgt = m_alarm;
        end else if (m_hit) begin
          m_ring = 1; m_armed = 0; m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model o_ring", o_ring, m_ring);
      chk("model o_armed", o_armed, m_armed);
      chk("model o_set_err", o_set_err, m_err);
      chk("model o_alarm_hour", o_alarm_hour, m_alarm / 60);
      chk("model o_alarm_min", o_alarm_min, m_alarm % 60);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tm(input int h, input int m, input int s);
    hour = 5'(h); min = 6'(m); sec = 6'(s);
  endtask

  task automatic pulse_set(input int h, input int m);
    i_set = 1'b1; i_set_hour = 5'(h); i_set_min = 6'(m);
    cyc();
    i_set = 1'b0;
  endtask

  task automatic do_snooze();
    i_snooze = 1'b1; cyc(); i_snooze = 1'b0;
  endtask

  task automatic do_stop();
    i_stop = 1'b1; cyc(); i_stop = 1'b0;
  endtask

  task automatic hit_at(input int h, input int m);
    int t;
    t = (h * 60 + m + 1439) % 1440;
    tm(t / 60, t % 60, 59); cyc();
    tm(h, m, 0); cyc();
  endtask

  initial begin
    reset = 1'b0; tm(0, 0, 0);
    i_alarm_en = 0; i_set = 0; i_set_hour = '0; i_set_min = '0; i_snooze = 0; i_stop = 0;
    cyc(3);
    chk("reset o_ring", o_ring, 0);
    chk("reset o_alarm_hour", o_alarm_hour, 0);
    reset = 1'b1;
    cmp_en = 1'b1;
    cyc();
    chk("post-reset o_armed", o_armed, 0);

    tm(7, 29, 58); i_alarm_en = 1'b1; cyc();
    chk("enable arms", o_armed, 1);
    pulse_set(7, 30);
    chk("set hour", o_alarm_hour, 7);
    chk("set min", o_alarm_min, 30);

    tm(7, 29, 59); cyc();
    chk("no ring before 07:30", o_ring, 0);
    tm(7, 30, 0); cyc();
    chk("ring at 07:30", o_ring, 1);
    chk("armed low while ringing", o_armed, 0);
    for (int s = 1; s < 60; s++) begin
      tm(7, 30, s); cyc(2);
    end
    chk("still ringing after 59 ticks", o_ring, 1);
    tm(7, 31, 0); cyc();
    chk("ring timeout", o_ring, 0);
    chk("armed after timeout", o_armed, 1);

    pulse_set(24, 0);
    chk("set_err hour 24", o_set_err, 1);
    chk("alarm hour kept", o_alarm_hour, 7);
    cyc();
    chk("set_err one cycle", o_set_err, 0);
    pulse_set(7, 60);
    chk("set_err min 60", o_set_err, 1);
    chk("alarm min kept", o_alarm_min, 30);
    cyc();

    do_snooze(); do_stop();
    chk("buttons ignored when armed", o_ring, 0);

    hit_at(7, 30);
    chk("ring again 07:30", o_ring, 1);
    do_snooze();
    chk("snooze 1 silences", o_ring, 0);
    hit_at(7, 35);
    chk("ring 07:35", o_ring, 1);
    do_snooze(); hit_at(7, 40);
    chk("ring 07:40", o_ring, 1);
    do_snooze(); hit_at(7, 45);
    chk("ring 07:45", o_ring, 1);
    do_snooze();
    chk("fourth snooze ignored", o_ring, 1);
    do_stop();
    chk("stop silences", o_ring, 0);
    hit_at(7, 30);
    chk("target restored 07:30", o_ring, 1);
    do_stop();
    cyc(100);
    chk("static sec=0 no retrigger", o_ring, 0);

    pulse_set(23, 58);
    hit_at(23, 58);
    chk("ring 23:58", o_ring, 1);
    tm(23, 58, 10); cyc();
    do_snooze();
    chk("snooze at 23:58", o_ring, 0);
    hit_at(0, 2);
    chk("no ring 00:02", o_ring, 0);
    hit_at(0, 3);
    chk("ring 00:03 after wrap", o_ring, 1);
    do_stop();

    tm(23, 57, 59); cyc();
    tm(23, 58, 0);
    pulse_set(6, 0);
    chk("set beats hit", o_ring, 0);
    chk("set beats hit hour", o_alarm_hour, 6);

    hit_at(6, 0);
    chk("ring 06:00", o_ring, 1);
    i_alarm_en = 1'b0; cyc();
    chk("disable drops ring", o_ring, 0);
    chk("disable clears armed", o_armed, 0);
    i_alarm_en = 1'b1; cyc();
    chk("re-enable arms", o_armed, 1);

    hit_at(6, 0);
    chk("ring before async reset", o_ring, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset o_ring", o_ring, 0);
    chk("async reset alarm hour", o_alarm_hour, 0);
    chk("async reset alarm min", o_alarm_min, 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
